wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order MEM/WB result and the out-of-band completions of the multiplier and divider.
- Each long-latency unit gets a one-entry holding buffer with a valid/ready handshake.
- Fixed priority goes to the pipeline, with round-robin between the units and a starvation guard that stalls the pipeline.
- Drives the registered write-back triple (we/rd/data) toward ID, alongside the Writeback stage.

---
 rtl/wb_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the MEM/WB result has priority over buffered
// multiplier/divider completions, with round-robin between units and a starvation guard.
module wb_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            Rst_n,
   input  logic            hold,
   input  logic            pipe_we,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_data,
   input  logic            mul_valid,
   output logic            mul_ready,
   input  logic [4:0]      mul_rd,
   input  logic [XLEN-1:0] mul_data,
   input  logic            div_valid,
   output logic            div_ready,
   input  logic [4:0]      div_rd,
   input  logic [XLEN-1:0] div_data,
   output logic            mul_pending,
   output logic            div_pending,
   output logic            pipe_stall,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic            mul_v_q, mul_v_d, div_v_q, div_v_d;
   logic [4:0]      mul_rd_q, mul_rd_d, div_rd_q, div_rd_d;
   logic [XLEN-1:0] mul_data_q, mul_data_d, div_data_q, div_data_d;
   logic [3:0]      starve_q, starve_d;
   logic            rr_q, rr_d;   // 0: multiplier next, 1: divider next
   logic            wb_we_q, wb_we_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;

   logic any_buf, pipe_req, starved, buf_win, pipe_win, pick_div, mul_grant, div_grant;

   always_comb begin
      mul_v_d    = mul_v_q;
      mul_rd_d   = mul_rd_q;
      mul_data_d = mul_data_q;
      div_v_d    = div_v_q;
      div_rd_d   = div_rd_q;
      div_data_d = div_data_q;
      starve_d   = starve_q;
      rr_d       = rr_q;
      wb_we_d    = wb_we_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;

      any_buf   = mul_v_q || div_v_q;
      pipe_req  = pipe_we && (pipe_rd != 5'd0);
      starved   = (starve_q == LIMIT) && any_buf;
      pipe_stall = !hold && starved;
      buf_win   = !hold && any_buf && (starved || !pipe_req);
      pipe_win  = !hold && !starved && pipe_req;
      pick_div  = div_v_q && (!mul_v_q || rr_q);
      mul_grant = buf_win && !pick_div;
      div_grant = buf_win && pick_div;
      mul_ready = !hold && (!mul_v_q || mul_grant);
      div_ready = !hold && (!div_v_q || div_grant);

      if (!hold) begin
         // Drain first so a full buffer can refill in the same cycle; rd=0 results are dropped.
         if (mul_grant) mul_v_d = 1'b0;
         if (mul_valid && mul_ready) begin
            mul_v_d    = (mul_rd != 5'd0);
            mul_rd_d   = mul_rd;
            mul_data_d = mul_data;
         end
         if (div_grant) div_v_d = 1'b0;
         if (div_valid && div_ready) begin
            div_v_d    = (div_rd != 5'd0);
            div_rd_d   = div_rd;
            div_data_d = div_data;
         end

         if (buf_win && mul_v_q && div_v_q) rr_d = !rr_q;

         if (buf_win || !any_buf)             starve_d = 4'd0;
         else if (pipe_win && starve_q != LIMIT) starve_d = starve_q + 4'd1;

         wb_we_d = pipe_win || buf_win;
         if (pipe_win) begin
            wb_rd_d   = pipe_rd;
            wb_data_d = pipe_data;
         end else if (mul_grant) begin
            wb_rd_d   = mul_rd_q;
            wb_data_d = mul_data_q;
         end else if (div_grant) begin
            wb_rd_d   = div_rd_q;
            wb_data_d = div_data_q;
         end
      end
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         mul_v_q    <= 1'b0;
         mul_rd_q   <= 5'd0;
         mul_data_q <= '0;
         div_v_q    <= 1'b0;
         div_rd_q   <= 5'd0;
         div_data_q <= '0;
         starve_q   <= 4'd0;
         rr_q       <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= '0;
      end else begin
         mul_v_q    <= mul_v_d;
         mul_rd_q   <= mul_rd_d;
         mul_data_q <= mul_data_d;
         div_v_q    <= div_v_d;
         div_rd_q   <= div_rd_d;
         div_data_q <= div_data_d;
         starve_q   <= starve_d;
         rr_q       <= rr_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign mul_pending = mul_v_q;
   assign div_pending = div_v_q;
   assign wb_we       = wb_we_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
endmodule
